// File: rtl/mips_mem_pkg.sv
// Shared types for the unified memory port arbiter.
// State encoding, grant encoding and default widths.
package mips_mem_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data ports.
// D wins unless it has already won MAX_STREAK times while I waited.
module mem_arb_pick
  import mips_mem_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic take,
  output gnt_t gnt,
  output logic any
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak;

  always_comb begin
    any = i_req | d_req;
    gnt = GNT_I;
    if (d_req && (!i_req || streak < SMAX))
      gnt = GNT_D;
  end

  // Only a D win over a waiting I extends the streak.
  always_ff @(posedge clk) begin
    if (!rst) begin
      streak <= '0;
    end else if (take) begin
      if (gnt == GNT_D && i_req) begin
        if (streak != SMAX)
          streak <= streak + SW'(1);
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory shared by fetch (I) and data (D).
// One transaction at a time; ack pulses in RESP.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  state_t state, state_n;
  gnt_t   gnt;
  logic   any;
  logic   take;

  assign take = (state == IDLE) && any;
  assign busy = (state != IDLE);

  mem_arb_pick #(
    .MAX_STREAK(MAX_STREAK)
  ) u_pick (
    .clk  (clk),
    .rst  (rst),
    .i_req(i_req),
    .d_req(d_req),
    .take (take),
    .gnt  (gnt),
    .any  (any)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (any)
          state_n = (gnt == GNT_D) ? BUSY_D : BUSY_I;
      BUSY_I, BUSY_D:
        if (mem_ready)
          state_n = RESP;
      RESP:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // mem_ready outside BUSY is ignored by construction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            mem_req <= 1'b1;
            if (gnt == GNT_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
            end
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            i_rdata <= mem_rdata;
            i_ack   <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we)
              d_rdata <= mem_rdata;
            d_ack <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
